// File: rtl/psram_port_arbiter.sv
// Two-port (video + CPU) arbiter in front of a single PSRAM controller.
// Optional CPU starvation guard is built when PSRAM_ARB_STARVE_GUARD_EN is defined.
module psram_port_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_mem,
    input  logic        reset_n,
    input  logic        vid_rd,
    input  logic [21:0] vid_addr,
    input  logic        vid_active,
    output logic        vid_busy,
    output logic [31:0] vid_q,
    output logic        vid_q_valid,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [21:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        cpu_busy,
    output logic [31:0] cpu_q,
    output logic        cpu_q_valid,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [21:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_busy,
    input  logic [31:0] mem_q,
    input  logic        mem_q_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t      state_r;
    logic        owner_r;
    logic        wr_guard_r;
    logic        vid_pend_r;
    logic [21:0] vid_addr_r;
    logic        cpu_pend_r;
    logic        cpu_we_r;
    logic [21:0] cpu_addr_r;
    logic [31:0] cpu_wdata_r;
    logic [3:0]  cpu_be_r;

    logic        vid_req_s;
    logic        cpu_req_s;
    logic [21:0] vid_req_addr_s;
    logic [21:0] cpu_req_addr_s;
    logic [31:0] cpu_req_wdata_s;
    logic [3:0]  cpu_req_be_s;
    logic        cpu_req_we_s;
    logic        cpu_first_s;
    logic        grant_vid_s;
    logic        grant_cpu_s;
    logic        rd_done_s;
    logic        wr_done_s;
    logic        vid_pend_nxt_s;
    logic        cpu_pend_nxt_s;
    logic        vid_own_nxt_s;
    logic        cpu_own_nxt_s;

`ifdef PSRAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_r;
    logic       unused_cfg_s;

    assign unused_cfg_s = 1'b0;

    // Starvation counter: video grants made while the CPU waits.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_r <= 4'd0;
        end else if (!vid_active || grant_cpu_s) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_vid_s && cpu_req_s && (starve_cnt_r != 4'hF)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign cpu_first_s = (starve_cnt_r >= LIMIT_C) & vid_req_s & cpu_req_s;
`else
    logic unused_cfg_s;

    assign unused_cfg_s = vid_active | (STARVE_LIMIT == 32'sd0);
    assign cpu_first_s  = 1'b0;
`endif

    // Request view including a pulse arriving this cycle, so grants cost no extra cycle.
    always_comb begin
        vid_req_s       = vid_pend_r | vid_rd;
        cpu_req_s       = cpu_pend_r | cpu_rd | cpu_wr;
        vid_req_addr_s  = vid_pend_r ? vid_addr_r  : vid_addr;
        cpu_req_addr_s  = cpu_pend_r ? cpu_addr_r  : cpu_addr;
        cpu_req_wdata_s = cpu_pend_r ? cpu_wdata_r : cpu_wdata;
        cpu_req_be_s    = cpu_pend_r ? cpu_be_r    : cpu_be;
        cpu_req_we_s    = cpu_pend_r ? cpu_we_r    : cpu_wr;

        grant_vid_s = (state_r == IDLE) & ~mem_busy & vid_req_s & ~cpu_first_s;
        grant_cpu_s = (state_r == IDLE) & ~mem_busy & cpu_req_s & ~grant_vid_s;
        rd_done_s   = (state_r == RD_WAIT) & mem_q_valid;
        wr_done_s   = (state_r == WR_WAIT) & ~mem_wr & ~wr_guard_r & ~mem_busy;

        vid_pend_nxt_s = grant_vid_s ? 1'b0 : vid_req_s;
        cpu_pend_nxt_s = grant_cpu_s ? 1'b0 : cpu_req_s;
        vid_own_nxt_s  = grant_vid_s | ((state_r == RD_WAIT) & ~owner_r & ~rd_done_s);
        cpu_own_nxt_s  = grant_cpu_s |
                         ((state_r != IDLE) & owner_r & ~rd_done_s & ~wr_done_s);
    end

    // Arbitration FSM with request latches and registered outputs.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            owner_r     <= 1'b0;
            wr_guard_r  <= 1'b0;
            vid_pend_r  <= 1'b0;
            vid_addr_r  <= 22'd0;
            cpu_pend_r  <= 1'b0;
            cpu_we_r    <= 1'b0;
            cpu_addr_r  <= 22'd0;
            cpu_wdata_r <= 32'd0;
            cpu_be_r    <= 4'd0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= 22'd0;
            mem_wdata   <= 32'd0;
            mem_be      <= 4'd0;
            vid_q       <= 32'd0;
            vid_q_valid <= 1'b0;
            cpu_q       <= 32'd0;
            cpu_q_valid <= 1'b0;
            vid_busy    <= 1'b0;
            cpu_busy    <= 1'b0;
        end else begin
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            vid_q_valid <= 1'b0;
            cpu_q_valid <= 1'b0;
            vid_pend_r  <= vid_pend_nxt_s;
            cpu_pend_r  <= cpu_pend_nxt_s;
            vid_busy    <= vid_pend_nxt_s | vid_own_nxt_s;
            cpu_busy    <= cpu_pend_nxt_s | cpu_own_nxt_s;

            if (!vid_pend_r && vid_rd) begin
                vid_addr_r <= vid_addr;
            end
            if (!cpu_pend_r && (cpu_rd || cpu_wr)) begin
                cpu_we_r    <= cpu_wr;
                cpu_addr_r  <= cpu_addr;
                cpu_wdata_r <= cpu_wdata;
                cpu_be_r    <= cpu_be;
            end

            case (state_r)
                IDLE: begin
                    if (grant_vid_s) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= vid_req_addr_s;
                        mem_be   <= 4'hF;
                        owner_r  <= 1'b0;
                        state_r  <= RD_WAIT;
                    end else if (grant_cpu_s) begin
                        mem_addr  <= cpu_req_addr_s;
                        mem_wdata <= cpu_req_wdata_s;
                        mem_be    <= cpu_req_be_s;
                        owner_r   <= 1'b1;
                        if (cpu_req_we_s) begin
                            mem_wr     <= 1'b1;
                            wr_guard_r <= 1'b1;
                            state_r    <= WR_WAIT;
                        end else begin
                            mem_rd  <= 1'b1;
                            state_r <= RD_WAIT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (mem_q_valid) begin
                        if (owner_r) begin
                            cpu_q       <= mem_q;
                            cpu_q_valid <= 1'b1;
                        end else begin
                            vid_q       <= mem_q;
                            vid_q_valid <= 1'b1;
                        end
                        state_r <= IDLE;
                    end else begin
                        state_r <= RD_WAIT;
                    end
                end
                WR_WAIT: begin
                    // mem_busy is not trusted during the write pulse or the cycle after it.
                    if (mem_wr) begin
                        state_r <= WR_WAIT;
                    end else if (wr_guard_r) begin
                        wr_guard_r <= 1'b0;
                    end else if (!mem_busy) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WR_WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Directed self-checking bench for psram_port_arbiter (default or guard build).
module tb_psram_port_arbiter;

    logic        clk_mem = 1'b0;
    logic        reset_n = 1'b0;
    logic        vid_rd = 1'b0;
    logic [21:0] vid_addr = 22'd0;
    logic        vid_active = 1'b0;
    logic        vid_busy;
    logic [31:0] vid_q;
    logic        vid_q_valid;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [21:0] cpu_addr = 22'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [3:0]  cpu_be = 4'd0;
    logic        cpu_busy;
    logic [31:0] cpu_q;
    logic        cpu_q_valid;
    logic        mem_rd;
    logic        mem_wr;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_q = 32'd0;
    logic        mem_q_valid = 1'b0;

    int total = 0;
    int bad = 0;

    psram_port_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk_mem(clk_mem), .reset_n(reset_n),
        .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_active(vid_active),
        .vid_busy(vid_busy), .vid_q(vid_q), .vid_q_valid(vid_q_valid),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_busy(cpu_busy), .cpu_q(cpu_q), .cpu_q_valid(cpu_q_valid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_busy(mem_busy), .mem_q(mem_q), .mem_q_valid(mem_q_valid)
    );

    always #5 clk_mem = ~clk_mem;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_mem);
        @(negedge clk_mem);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {26'd0, mem_rd, mem_wr, vid_q_valid, cpu_q_valid, vid_busy, cpu_busy}, 32'd0);
        chk({tag, "_addr"}, {10'd0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_be"}, {28'd0, mem_be}, 32'd0);
        chk({tag, "_vid_q"}, vid_q, 32'd0);
        chk({tag, "_cpu_q"}, cpu_q, 32'd0);
    endtask

    initial begin
        int vid_grants;
        int pulses;
        logic cpu_seen;

        // Reset state
        repeat (2) @(negedge clk_mem);
        chk_all_zero("reset");
        reset_n = 1'b1;
        cyc();

        // mem_q_valid in IDLE is discarded
        mem_q_valid = 1'b1; mem_q = 32'h11111111;
        cyc();
        chk("idle_qv_vid", {31'd0, vid_q_valid}, 32'd0);
        chk("idle_qv_cpu", {31'd0, cpu_q_valid}, 32'd0);
        mem_q_valid = 1'b0;

        // V1: single video read
        vid_rd = 1'b1; vid_addr = 22'h000100;
        cyc();
        vid_rd = 1'b0;
        chk("v1_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("v1_mem_addr", {10'd0, mem_addr}, 32'h00000100);
        chk("v1_vid_busy", {31'd0, vid_busy}, 32'd1);
        cyc();
        chk("v1_rd_one_cycle", {31'd0, mem_rd}, 32'd0);
        mem_q_valid = 1'b1; mem_q = 32'hDEADBEEF;
        cyc();
        mem_q_valid = 1'b0;
        chk("v1_vid_qv", {31'd0, vid_q_valid}, 32'd1);
        chk("v1_vid_q", vid_q, 32'hDEADBEEF);
        chk("v1_cpu_qv", {31'd0, cpu_q_valid}, 32'd0);
        cyc();
        chk("v1_vid_qv_end", {31'd0, vid_q_valid}, 32'd0);
        chk("v1_vid_busy_end", {31'd0, vid_busy}, 32'd0);

        // V2: simultaneous cpu_wr and vid_rd
        vid_rd = 1'b1; vid_addr = 22'h000200;
        cpu_wr = 1'b1; cpu_addr = 22'h3ABCDE; cpu_wdata = 32'h12345678; cpu_be = 4'hF;
        cyc();
        vid_rd = 1'b0; cpu_wr = 1'b0;
        chk("v2_vid_first", {30'd0, mem_rd, mem_wr}, 32'd2);
        chk("v2_vid_addr", {10'd0, mem_addr}, 32'h00000200);
        chk("v2_cpu_busy_pend", {31'd0, cpu_busy}, 32'd1);
        cyc();
        mem_q_valid = 1'b1; mem_q = 32'hA5A50001;
        cyc();
        mem_q_valid = 1'b0;
        chk("v2_vid_qv", {31'd0, vid_q_valid}, 32'd1);
        chk("v2_no_wr_yet", {31'd0, mem_wr}, 32'd0);
        cyc();
        chk("v2_mem_wr", {30'd0, mem_rd, mem_wr}, 32'd1);
        chk("v2_wr_addr", {10'd0, mem_addr}, 32'h003ABCDE);
        chk("v2_wr_data", mem_wdata, 32'h12345678);
        chk("v2_wr_be", {28'd0, mem_be}, 32'hF);
        mem_busy = 1'b1;
        cyc();
        chk("v2_busy_guard", {31'd0, cpu_busy}, 32'd1);
        mem_busy = 1'b0;
        cyc();
        chk("v2_busy_ignore_low", {31'd0, cpu_busy}, 32'd1);
        mem_busy = 1'b1;
        cyc();
        chk("v2_busy_hold", {31'd0, cpu_busy}, 32'd1);
        mem_busy = 1'b0;
        cyc();
        chk("v2_busy_release", {31'd0, cpu_busy}, 32'd0);

        // V3: cpu_rd while video read outstanding; second pulse while pending ignored
        vid_rd = 1'b1; vid_addr = 22'h000300;
        cyc();
        vid_rd = 1'b0;
        chk("v3_vid_rd", {31'd0, mem_rd}, 32'd1);
        cpu_rd = 1'b1; cpu_addr = 22'h000400;
        cyc();
        chk("v3_no_rd_wait1", {31'd0, mem_rd}, 32'd0);
        chk("v3_cpu_busy", {31'd0, cpu_busy}, 32'd1);
        cpu_addr = 22'h000555;
        cyc();
        cpu_rd = 1'b0;
        chk("v3_no_rd_wait2", {31'd0, mem_rd}, 32'd0);
        mem_q_valid = 1'b1; mem_q = 32'hCAFEF00D;
        cyc();
        mem_q_valid = 1'b0;
        chk("v3_vid_qv", {31'd0, vid_q_valid}, 32'd1);
        chk("v3_vid_q", vid_q, 32'hCAFEF00D);
        chk("v3_no_rd_exit", {31'd0, mem_rd}, 32'd0);
        cyc();
        chk("v3_cpu_rd", {31'd0, mem_rd}, 32'd1);
        chk("v3_cpu_addr", {10'd0, mem_addr}, 32'h00000400);
        cyc();
        mem_q_valid = 1'b1; mem_q = 32'h0BADC0DE;
        cyc();
        mem_q_valid = 1'b0;
        chk("v3_cpu_qv", {31'd0, cpu_q_valid}, 32'd1);
        chk("v3_cpu_q", cpu_q, 32'h0BADC0DE);
        chk("v3_vid_qv_low", {31'd0, vid_q_valid}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (cpu_q_valid) pulses++;
        end
        chk("v3_cpu_qv_once", 32'(pulses), 32'd0);
        chk("v3_cpu_busy_end", {31'd0, cpu_busy}, 32'd0);

        // V4: pending CPU read against a video burst
        vid_grants = 0;
        cpu_seen = 1'b0;
        vid_active = 1'b1;
        vid_rd = 1'b1; vid_addr = 22'h010000;
        cpu_rd = 1'b1; cpu_addr = 22'h020000;
        for (int c = 0; c < 1000 && !cpu_seen; c++) begin
            cyc();
            cpu_rd = 1'b0;
            mem_q_valid = 1'b0;
            if (mem_rd) begin
                mem_q_valid = 1'b1;
                mem_q = 32'(c);
                if (mem_addr == 22'h020000) begin
                    cpu_seen = 1'b1;
                    mem_q = 32'h5A5A5A5A;
                end else begin
                    vid_grants++;
                    if (vid_grants >= 80) vid_rd = 1'b0;
                end
            end
        end
        vid_rd = 1'b0;
        chk("v4_cpu_granted", {31'd0, cpu_seen}, 32'd1);
`ifdef PSRAM_ARB_STARVE_GUARD_EN
        chk("v4_vid_grants", 32'(vid_grants), 32'd8);
`else
        chk("v4_vid_grants", 32'(vid_grants), 32'd80);
`endif
        cyc();
        mem_q_valid = 1'b0;
        chk("v4_cpu_qv", {31'd0, cpu_q_valid}, 32'd1);
        chk("v4_cpu_q", cpu_q, 32'h5A5A5A5A);
        for (int i = 0; i < 20; i++) begin
            cyc();
            mem_q_valid = 1'b0;
            if (mem_rd) mem_q_valid = 1'b1;
        end
        mem_q_valid = 1'b0;
        vid_active = 1'b0;
        cyc();
        chk("v4_drained", {30'd0, vid_busy, cpu_busy}, 32'd0);

        // V5: reset while in RD_WAIT, then a stale mem_q_valid
        vid_rd = 1'b1; vid_addr = 22'h000777;
        cyc();
        vid_rd = 1'b0;
        chk("v5_vid_rd", {31'd0, mem_rd}, 32'd1);
        cyc();
        reset_n = 1'b0;
        #1;
        chk_all_zero("v5_in_reset");
        @(negedge clk_mem);
        reset_n = 1'b1;
        mem_q_valid = 1'b1; mem_q = 32'hFFFFFFFF;
        cyc();
        mem_q_valid = 1'b0;
        chk_all_zero("v5_stale_qv");
        cyc();
        chk_all_zero("v5_after");
        cpu_rd = 1'b1; cpu_addr = 22'h000123;
        cyc();
        cpu_rd = 1'b0;
        chk("v5_idle_grant", {31'd0, mem_rd}, 32'd1);
        chk("v5_idle_addr", {10'd0, mem_addr}, 32'h00000123);
        cyc();
        mem_q_valid = 1'b1; mem_q = 32'h00C0FFEE;
        cyc();
        mem_q_valid = 1'b0;
        chk("v5_cpu_qv", {31'd0, cpu_q_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
